pipeline_mem_arbiter: RTL and testbench

Two-client memory arbiter between the LC-3b pipeline's instruction-side and data-side line requests and the single physical memory port. It accepts cache-line (lc3b_burst, 128-bit, 8-word) read/write requests from each client and serialises them onto the physical memory with round-robin tie-breaking. It returns the line and a one-cycle response to the granted client. It sits directly downstream of the pipeline datapath's memory interface and upstream of physical memory.

---
 rtl/pipeline_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_mem_arbiter
// Description : Two-client (instruction / data) cache-line arbiter in front of
//               a single physical memory port. Requests are serialised with
//               round-robin tie-breaking; each transaction is latched on grant,
//               presented to memory, and answered with a one-cycle resp pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_mem_arbiter (
  input  logic         clk,
  input  logic         reset,

  // instruction-side client
  input  logic         i_read,
  input  logic [15:0]  i_address,
  output logic         i_resp,
  output logic [127:0] i_rdata,

  // data-side client
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  output logic         d_resp,
  output logic [127:0] d_rdata,

  // physical memory port
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
);

  localparam logic [15:0] LINE_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state;
  logic   last_d;   // 1 = data side was granted most recently
  logic   pend_d;
  logic   pick_d;

  // Arbitration decision: D wins alone, or on a tie when I was served last
  always_comb begin
    pend_d = d_read | d_write;
    pick_d = pend_d & (~i_read | ~last_d);
  end

  // Arbiter FSM; every output is a register updated here, so client inputs
  // only ever reach the memory port through the grant-time latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_d       <= 1'b0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          // pmem_resp is deliberately ignored here: nothing is outstanding
          if (i_read | pend_d) begin
            last_d <= pick_d;
            if (pick_d) begin
              state        <= SERVE_D;
              // read+write together is treated as a write
              pmem_write   <= d_write;
              pmem_read    <= ~d_write;
              pmem_address <= d_address & LINE_MASK;
              pmem_wdata   <= d_wdata;
            end else begin
              state        <= SERVE_I;
              pmem_write   <= 1'b0;
              pmem_read    <= 1'b1;
              pmem_address <= i_address & LINE_MASK;
              pmem_wdata   <= '0;
            end
          end
        end

        SERVE_I: begin
          if (pmem_resp) begin
            i_rdata    <= pmem_rdata;
            i_resp     <= 1'b1;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state      <= RESP;
          end
        end

        SERVE_D: begin
          if (pmem_resp) begin
            // writes leave the returned-line register untouched
            if (pmem_read) begin
              d_rdata <= pmem_rdata;
            end
            d_resp     <= 1'b1;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state      <= RESP;
          end
        end

        RESP: begin
          // one dead cycle lets the client drop its request before re-arbitration
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_mem_arbiter
// Description : Directed self-checking bench for pipeline_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_read;
  logic [15:0]  i_address;
  logic         i_resp;
  logic [127:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic         d_resp;
  logic [127:0] d_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] R_I  = 128'h01234567_89ABCDEF_00000000_DEADBEEF;
  localparam logic [127:0] W_D  = 128'hCAFEF00D_11223344_55667788_99AABBCC;
  localparam logic [127:0] JUNK = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;
  localparam logic [127:0] W_2  = 128'h0F0F0F0F_F0F0F0F0_A5A5A5A5_5A5A5A5A;

  logic [127:0] exp_i_rdata;
  logic [127:0] exp_d_rdata;

  pipeline_mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_resp       (i_resp),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_resp       (d_resp),
    .d_rdata      (d_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a grant edge in the tie test; completes the transaction
  // with an immediate pmem_resp, drops the served client's request on resp,
  // and re-asserts it once the arbiter is back in IDLE.
  task automatic serve(input bit exp_d, input logic [15:0] exp_addr, input logic [127:0] data);
    chk(exp_d ? "rr_grant_addr_d" : "rr_grant_addr_i", {112'd0, pmem_address}, {112'd0, exp_addr});
    chk("rr_strobe", {126'd0, pmem_read, pmem_write}, 128'd2);
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    step();
    pmem_resp = 1'b0;
    chk("rr_resp", {126'd0, i_resp, d_resp}, exp_d ? 128'd1 : 128'd2);
    if (exp_d) begin
      exp_d_rdata = data;
      chk("rr_d_rdata", d_rdata, exp_d_rdata);
      d_read = 1'b0;
    end else begin
      exp_i_rdata = data;
      chk("rr_i_rdata", i_rdata, exp_i_rdata);
      i_read = 1'b0;
    end
    step();
    if (exp_d) d_read = 1'b1;
    else       i_read = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    i_read     = 1'b0;
    i_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    step();
    step();
    reset = 1'b0;

    // ---------------- reset state
    chk("rst_strobes", {124'd0, i_resp, d_resp, pmem_read, pmem_write}, 128'd0);
    chk("rst_addr", {112'd0, pmem_address}, 128'd0);
    chk("rst_wdata", pmem_wdata, 128'd0);
    chk("rst_i_rdata", i_rdata, 128'd0);
    chk("rst_d_rdata", d_rdata, 128'd0);

    // ---------------- instruction read, memory answers after 3 cycles
    i_read    = 1'b1;
    i_address = 16'h1234;
    step();
    chk("ird_strobe", {126'd0, pmem_read, pmem_write}, 128'd2);
    chk("ird_addr", {112'd0, pmem_address}, 128'h1230);
    step();
    chk("ird_hold1", {127'd0, pmem_read}, 128'd1);
    step();
    chk("ird_hold2", {127'd0, pmem_read}, 128'd1);
    pmem_resp  = 1'b1;
    pmem_rdata = R_I;
    step();
    pmem_resp  = 1'b0;
    exp_i_rdata = R_I;
    chk("ird_resp", {126'd0, i_resp, d_resp}, 128'd2);
    chk("ird_rdata", i_rdata, exp_i_rdata);
    chk("ird_strobe_off", {126'd0, pmem_read, pmem_write}, 128'd0);
    i_read = 1'b0;
    step();
    chk("ird_resp_once", {126'd0, i_resp, d_resp}, 128'd0);
    chk("ird_rdata_hold", i_rdata, exp_i_rdata);

    // ---------------- data write, unaligned address
    d_write   = 1'b1;
    d_address = 16'h400F;
    d_wdata   = W_D;
    step();
    chk("dwr_strobe", {126'd0, pmem_read, pmem_write}, 128'd1);
    chk("dwr_addr", {112'd0, pmem_address}, 128'h4000);
    chk("dwr_wdata", pmem_wdata, W_D);
    step();
    chk("dwr_hold", {126'd0, pmem_read, pmem_write}, 128'd1);
    pmem_resp  = 1'b1;
    pmem_rdata = JUNK;
    step();
    pmem_resp = 1'b0;
    chk("dwr_resp", {126'd0, i_resp, d_resp}, 128'd1);
    chk("dwr_rdata_kept", d_rdata, exp_d_rdata);
    d_write = 1'b0;
    step();
    chk("dwr_resp_once", {126'd0, i_resp, d_resp}, 128'd0);

    // ---------------- simultaneous requests from reset: D,I,D,I
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    chk("rr_rst_i_rdata", i_rdata, exp_i_rdata);
    i_read    = 1'b1;
    i_address = 16'h1117;
    d_read    = 1'b1;
    d_address = 16'h222A;
    step();
    serve(1'b1, 16'h2220, 128'h11);
    step();
    serve(1'b0, 16'h1110, 128'h22);
    step();
    serve(1'b1, 16'h2220, 128'h33);
    step();
    serve(1'b0, 16'h1110, 128'h44);
    i_read = 1'b0;
    d_read = 1'b0;
    step();
    step();
    chk("rr_idle", {124'd0, i_resp, d_resp, pmem_read, pmem_write}, 128'd0);

    // ---------------- address change during SERVE_D is ignored
    d_read    = 1'b1;
    d_address = 16'h2000;
    step();
    d_address = 16'h3000;
    chk("lat_addr0", {112'd0, pmem_address}, 128'h2000);
    step();
    chk("lat_addr1", {112'd0, pmem_address}, 128'h2000);
    step();
    chk("lat_addr2", {112'd0, pmem_address}, 128'h2000);
    pmem_resp  = 1'b1;
    pmem_rdata = 128'h5555;
    step();
    pmem_resp = 1'b0;
    exp_d_rdata = 128'h5555;
    chk("lat_resp", {126'd0, i_resp, d_resp}, 128'd1);
    chk("lat_rdata", d_rdata, exp_d_rdata);
    d_read = 1'b0;
    step();

    // ---------------- reset two cycles into SERVE_I
    i_read    = 1'b1;
    i_address = 16'h5000;
    step();
    chk("abt_strobe", {127'd0, pmem_read}, 128'd1);
    step();
    step();
    reset = 1'b1;
    step();
    reset  = 1'b0;
    i_read = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    chk("abt_off", {124'd0, i_resp, d_resp, pmem_read, pmem_write}, 128'd0);
    step();
    chk("abt_no_resp", {126'd0, i_resp, d_resp}, 128'd0);
    pmem_resp  = 1'b1;
    pmem_rdata = JUNK;
    step();
    pmem_resp = 1'b0;
    chk("stray_resp0", {124'd0, i_resp, d_resp, pmem_read, pmem_write}, 128'd0);
    step();
    chk("stray_resp1", {126'd0, i_resp, d_resp}, 128'd0);
    chk("stray_i_rdata", i_rdata, exp_i_rdata);

    // ---------------- read and write together: write wins
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 16'h6008;
    d_wdata   = W_2;
    step();
    chk("rw_strobe", {126'd0, pmem_read, pmem_write}, 128'd1);
    chk("rw_addr", {112'd0, pmem_address}, 128'h6000);
    chk("rw_wdata", pmem_wdata, W_2);
    pmem_resp  = 1'b1;
    pmem_rdata = JUNK;
    step();
    pmem_resp = 1'b0;
    chk("rw_resp", {126'd0, i_resp, d_resp}, 128'd1);
    chk("rw_rdata_kept", d_rdata, exp_d_rdata);
    d_read  = 1'b0;
    d_write = 1'b0;
    step();
    chk("rw_done", {124'd0, i_resp, d_resp, pmem_read, pmem_write}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
